servo_axis_tracker: RTL and testbench

- Per-axis tracking controller upstream of the RC servo PWM stage; one instance per axis (x, y).
- Conditions one asynchronous comparator input with a synchronizer and a debounce filter.
- Ramps a saturating position word up or down at a fixed step rate according to the filtered comparator level.
- Presents that position word to the PWM generator, which converts it to servo pulse width.

---
 rtl/servo_axis_tracker.sv | 93 +++++++++
 tb/tb_servo_axis_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_axis_tracker.sv
// rtl/servo_axis_tracker.sv - per-axis servo position tracker
// Synchronized, debounced comparator drives a saturating position ramp stepped by a fixed-rate tick.
module servo_axis_tracker #(
  parameter int POS_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 16,
  parameter int STEP_DIV    = 50000,
  parameter int POS_MIN     = 16,
  parameter int POS_MAX     = 240,
  parameter int POS_RESET   = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             comp_async_i,
  output logic [POS_W-1:0] pos_o,
  output logic             pos_valid_o,
  output logic             comp_clean_o,
  output logic             at_limit_o
);

  localparam int FCNT_W = $clog2(FILT_CNT) + 1;
  localparam int SCNT_W = $clog2(STEP_DIV);
  localparam logic [POS_W-1:0] P_MIN   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_RESET = POS_W'(POS_RESET);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   clean_q, clean_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic                   tick;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic                   valid_q, valid_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign tick = (scnt_q == SCNT_W'(STEP_DIV - 1));

  // Any disagreement run shorter than FILT_CNT cycles is discarded.
  always_comb begin
    clean_d = clean_q;
    fcnt_d  = '0;
    if (s != clean_q) begin
      if (fcnt_q == FCNT_W'(FILT_CNT - 1)) begin
        clean_d = s;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_comb begin
    scnt_d = tick ? '0 : scnt_q + SCNT_W'(1);
  end

  // Step direction uses the pre-edge clean level; limits are never crossed.
  always_comb begin
    pos_d = pos_q;
    if (tick && ena) begin
      if (clean_q && (pos_q < P_MAX)) begin
        pos_d = pos_q + POS_W'(1);
      end else if (!clean_q && (pos_q > P_MIN)) begin
        pos_d = pos_q - POS_W'(1);
      end
    end
    valid_d = (pos_d != pos_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      clean_q <= 1'b0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      pos_q   <= P_RESET;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], comp_async_i};
      clean_q <= clean_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
    end
  end

  assign pos_o        = pos_q;
  assign pos_valid_o  = valid_q;
  assign comp_clean_o = clean_q;
  assign at_limit_o   = (pos_q == P_MIN) || (pos_q == P_MAX);

endmodule

// File: tb/tb_servo_axis_tracker.sv
// tb/tb_servo_axis_tracker.sv - self-checking bench for servo_axis_tracker
// Directed table, hand sequences and randomized runs against an edge-history reference model.
module tb_servo_axis_tracker;

  localparam int POS_W = 8;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int STEP  = 8;
  localparam int PMIN  = 16;
  localparam int PMAX  = 240;
  localparam int PRST  = 128;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             comp_async_i;
  logic [POS_W-1:0] pos_o;
  logic             pos_valid_o;
  logic             comp_clean_o;
  logic             at_limit_o;

  servo_axis_tracker #(
    .POS_W(POS_W), .SYNC_STAGES(SYNC), .FILT_CNT(FILT), .STEP_DIV(STEP),
    .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_RESET(PRST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .comp_async_i(comp_async_i),
    .pos_o(pos_o), .pos_valid_o(pos_valid_o), .comp_clean_o(comp_clean_o),
    .at_limit_o(at_limit_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: edges since reset, history of applied comparator values.
  bit in_h[$];
  int n_m;
  bit clean_m;
  int pos_m;
  bit valid_m;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lim(input int p);
    return (p == PMIN) || (p == PMAX);
  endfunction

  task automatic model_reset();
    n_m = 0;
    in_h.delete();
    clean_m = 1'b0;
    pos_m   = PRST;
    valid_m = 1'b0;
  endtask

  // Level seen by the filter just before edge e: the input applied SYNC edges earlier.
  function automatic bit s_seen(input int e);
    return (e > SYNC) ? in_h[e-SYNC-1] : 1'b0;
  endfunction

  task automatic model_edge(input bit c, input bit e);
    bit clean_pre;
    int pos_pre;
    bit all_diff;
    n_m++;
    in_h.push_back(c);
    clean_pre = clean_m;
    pos_pre   = pos_m;
    if (n_m >= FILT) begin
      all_diff = 1'b1;
      for (int j = 0; j < FILT; j++)
        if (s_seen(n_m - j) == clean_pre) all_diff = 1'b0;
      if (all_diff) clean_m = !clean_pre;
    end
    if ((n_m % STEP == 0) && e) begin
      if (clean_pre && pos_pre < PMAX) pos_m = pos_pre + 1;
      else if (!clean_pre && pos_pre > PMIN) pos_m = pos_pre - 1;
    end
    valid_m = (pos_m != pos_pre);
  endtask

  task automatic check_model();
    chk("model_pos", int'(pos_o), pos_m);
    chk("model_clean", int'(comp_clean_o), int'(clean_m));
    chk("model_valid", int'(pos_valid_o), int'(valid_m));
    chk("model_limit", int'(at_limit_o), int'(lim(pos_m)));
  endtask

  // Called at a negedge; applies inputs for one rising edge and checks at the next negedge.
  task automatic cyc(input bit c, input bit e);
    comp_async_i = c;
    ena          = e;
    @(posedge clk);
    model_edge(c, e);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    comp_async_i = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    chk("rst_pos", int'(pos_o), PRST);
    chk("rst_clean", int'(comp_clean_o), 0);
    chk("rst_valid", int'(pos_valid_o), 0);
    chk("rst_limit", int'(at_limit_o), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int edge_n;
    bit comp;
    bit en;
    int pos;
    bit clean;
    bit valid;
  } vec_t;

  vec_t tbl[$];
  int   pulses;
  int   bias;
  int   len;
  int   cnt;
  bit   rc;
  bit   re;
  bit   gc;

  initial begin
    rst_n = 1'b0;
    comp_async_i = 1'b0;
    ena = 1'b1;

    // Reset, first tick, debounce latency and enable gating.
    tbl.push_back('{7,  0, 1, 128, 0, 0});
    tbl.push_back('{8,  0, 1, 127, 0, 1});
    tbl.push_back('{9,  0, 1, 127, 0, 0});
    tbl.push_back('{14, 1, 1, 127, 0, 0});
    tbl.push_back('{15, 1, 1, 127, 1, 0});
    tbl.push_back('{16, 1, 1, 128, 1, 1});
    tbl.push_back('{17, 1, 1, 128, 1, 0});
    tbl.push_back('{24, 1, 1, 129, 1, 1});
    tbl.push_back('{25, 1, 1, 129, 1, 0});
    tbl.push_back('{32, 1, 1, 130, 1, 1});
    tbl.push_back('{33, 1, 0, 130, 1, 0});
    tbl.push_back('{40, 1, 0, 130, 1, 0});
    tbl.push_back('{56, 1, 0, 130, 1, 0});
    tbl.push_back('{63, 1, 1, 130, 1, 0});
    tbl.push_back('{64, 1, 1, 131, 1, 1});
    tbl.push_back('{65, 1, 1, 131, 1, 0});

    do_reset();
    foreach (tbl[i]) begin
      while (n_m < tbl[i].edge_n) cyc(tbl[i].comp, tbl[i].en);
      chk($sformatf("tbl%0d_pos", i), int'(pos_o), tbl[i].pos);
      chk($sformatf("tbl%0d_clean", i), int'(comp_clean_o), int'(tbl[i].clean));
      chk($sformatf("tbl%0d_valid", i), int'(pos_valid_o), int'(tbl[i].valid));
      chk($sformatf("tbl%0d_limit", i), int'(at_limit_o), 0);
    end

    // Glitch rejection: 3-cycle pulse is dropped, 4-cycle pulse flips the clean level.
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      gc = ((e >= 3 && e <= 5) || (e >= 13 && e <= 16));
      cyc(gc, 1'b1);
      if (e <= 12) chk("glitch3_clean", int'(comp_clean_o), 0);
      case (e)
        8:  chk("glitch_pos8", int'(pos_o), 127);
        16: chk("glitch_pos16", int'(pos_o), 126);
        17: chk("glitch4_clean17", int'(comp_clean_o), 0);
        18: chk("glitch4_clean18", int'(comp_clean_o), 1);
        21: chk("glitch4_clean21", int'(comp_clean_o), 1);
        22: chk("glitch4_clean22", int'(comp_clean_o), 0);
        24: chk("glitch_pos24", int'(pos_o), 125);
        default: ;
      endcase
    end

    // Saturation at both limits.
    for (int d = 0; d < 2; d++) begin
      do_reset();
      pulses = 0;
      for (int e = 1; e <= 968; e++) begin
        cyc(d == 0, 1'b1);
        if (e >= 900 && pos_valid_o) pulses++;
      end
      chk("sat_pos", int'(pos_o), (d == 0) ? PMAX : PMIN);
      chk("sat_limit", int'(at_limit_o), 1);
      chk("sat_pulses", pulses, 0);
    end

    // Asynchronous reset mid-step with the filter part-way through a change.
    do_reset();
    repeat (576) cyc(1'b1, 1'b1);
    chk("mid_pos", int'(pos_o), 200);
    repeat (4) cyc(1'b0, 1'b1);
    chk("mid_pos_hold", int'(pos_o), 200);
    chk("mid_clean_hold", int'(comp_clean_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pos", int'(pos_o), PRST);
    chk("async_clean", int'(comp_clean_o), 0);
    chk("async_valid", int'(pos_valid_o), 0);
    chk("async_limit", int'(at_limit_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("inrst_valid", int'(pos_valid_o), 0);
      chk("inrst_pos", int'(pos_o), PRST);
    end
    model_reset();
    rst_n = 1'b1;
    repeat (7) cyc(1'b0, 1'b1);
    chk("restart_pos7", int'(pos_o), PRST);
    cyc(1'b0, 1'b1);
    chk("restart_pos8", int'(pos_o), 127);
    chk("restart_valid8", int'(pos_valid_o), 1);

    // Randomized runs with drifting bias so both limits and glitches get exercised.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      bias = $urandom_range(90, 10);
      cnt = 0;
      while (cnt < 500) begin
        rc  = ($urandom_range(99, 0) < bias);
        re  = ($urandom_range(99, 0) < 90);
        len = $urandom_range(8, 1);
        for (int j = 0; j < len; j++) begin
          cyc(rc, re);
          cnt++;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
